// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   tx_state_t        transmitter FSM states
//   PAR_*             parity-mode selector values for the PARITY parameter
//   calc_pulse_width  clk cycles per bit (integer division, truncated)
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter that paces one serial bit.
//   clk       system clock
//   rstn      synchronous active-low reset (count cleared to 0)
//   load      reload the counter with load_val this cycle
//   load_val  reload value (bit length minus one)
//   tick      high while the count is 0, i.e. in the last cycle of a bit
// The counter stops at 0 until it is reloaded.
module uart_baud_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count_r;

  // Down-count with reload priority; saturate at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = (count_r == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Accepts a word on valid/ready and sends it
// LSB-first as start bit, DATA_WIDTH data bits, optional parity bit,
// and STOP_BITS stop bits.
//   clk    system clock
//   rstn   synchronous active-low reset
//   data   word to transmit, sampled only on the handshake edge
//   valid  producer has a word
//   ready  transmitter accepts a word this cycle (registered)
//   sig    serial line, idle high (registered)
//   busy   high from the cycle after accept until the last stop bit ends
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  sig,
  output logic                  busy
);

  localparam int PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int TMR_W       = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W       = $clog2(DATA_WIDTH) + 1;

  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_t             state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  handshake_s;
  logic                  load_s;
  logic                  tick_s;

  // Parity of the accepted word: even = XOR of bits, odd = its inverse.
  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] word);
    logic even_s;
    even_s = ^word;
    if (PARITY == PAR_ODD) begin
      return ~even_s;
    end else begin
      return even_s;
    end
  endfunction

  assign handshake_s = valid & ready & (state_r == TX_IDLE);

  // Reload the bit timer on accept and at the end of every bit.
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      TX_IDLE:                               load_s = handshake_s;
      TX_START, TX_DATA, TX_PARITY, TX_STOP: load_s = tick_s;
      default:                               load_s = 1'b0;
    endcase
  end

  uart_baud_cnt #(
    .WIDTH(TMR_W)
  ) u_baud_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load_s),
    .load_val (TMR_LOAD),
    .tick     (tick_s)
  );

  // Transmit FSM. sig and busy are registered from the state held during
  // the current cycle, so the line lags the FSM by exactly one clock; that
  // lag puts the start-bit edge one clock after the handshake edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= TX_IDLE;
      shift_r   <= '0;
      par_r     <= 1'b0;
      bit_cnt_r <= '0;
      sig       <= 1'b1;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          sig   <= 1'b1;
          busy  <= handshake_s;
          ready <= ~handshake_s;
          if (handshake_s) begin
            state_r   <= TX_START;
            shift_r   <= data;
            par_r     <= frame_parity(data);
            bit_cnt_r <= '0;
          end else begin
            state_r <= TX_IDLE;
          end
        end
        TX_START: begin
          sig   <= 1'b0;
          busy  <= 1'b1;
          ready <= 1'b0;
          if (tick_s) begin
            state_r <= TX_DATA;
          end else begin
            state_r <= TX_START;
          end
        end
        TX_DATA: begin
          sig   <= shift_r[0];
          busy  <= 1'b1;
          ready <= 1'b0;
          if (tick_s) begin
            shift_r <= shift_r >> 1;
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              state_r   <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end else begin
            state_r <= TX_DATA;
          end
        end
        TX_PARITY: begin
          sig   <= par_r;
          busy  <= 1'b1;
          ready <= 1'b0;
          if (tick_s) begin
            bit_cnt_r <= '0;
            state_r   <= TX_STOP;
          end else begin
            state_r <= TX_PARITY;
          end
        end
        TX_STOP: begin
          sig  <= 1'b1;
          busy <= 1'b1;
          // ready goes up together with the return to IDLE so that the
          // single IDLE cycle can already accept the next word.
          if (tick_s && (bit_cnt_r == LAST_STOP)) begin
            bit_cnt_r <= '0;
            ready     <= 1'b1;
            state_r   <= TX_IDLE;
          end else if (tick_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            ready     <= 1'b0;
          end else begin
            ready <= 1'b0;
          end
        end
        default: begin
          state_r   <= TX_IDLE;
          bit_cnt_r <= '0;
          sig       <= 1'b1;
          busy      <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a scoreboard queue.
// Three transmitters at 10 clk cycles per bit share clk and rstn:
//   index 0: no parity, 1 stop bit   (frame 100 cycles)
//   index 1: even parity, 2 stop bits (frame 120 cycles)
//   index 2: odd parity, 1 stop bit  (frame 110 cycles)
// Expected words are queued when sent; the line monitor pops one per frame
// and checks every cycle of every bit level against the expected frame.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int PW       = 10;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data_a  [3];
  logic       valid_a [3];
  logic       ready_a [3];
  logic       sig_a   [3];
  logic       busy_a  [3];

  int par_cfg  [3] = '{0, 2, 1};
  int stop_cfg [3] = '{1, 2, 1};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rstn(rstn), .data(data_a[0]), .valid(valid_a[0]),
    .ready(ready_a[0]), .sig(sig_a[0]), .busy(busy_a[0]));

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .PARITY(2), .STOP_BITS(2)) u_even (
    .clk(clk), .rstn(rstn), .data(data_a[1]), .valid(valid_a[1]),
    .ready(ready_a[1]), .sig(sig_a[1]), .busy(busy_a[1]));

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rstn(rstn), .data(data_a[2]), .valid(valid_a[2]),
    .ready(ready_a[2]), .sig(sig_a[2]), .busy(busy_a[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word, wait (bounded) for ready, let the handshake edge pass.
  // Returns at the falling edge after the handshake edge.
  task automatic send(input int idx, input logic [7:0] w, input bit hold, input bit push,
                      output int hs_cyc);
    bit got;
    got = 1'b0;
    data_a[idx]  = w;
    valid_a[idx] = 1'b1;
    if (push) exp_q.push_back(w);
    for (int i = 0; i < 400; i++) begin
      if (ready_a[idx] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("send_ready_wait%0d", idx), 32'(got), 32'd1);
    @(negedge clk);
    hs_cyc = cyc;
    if (!hold) valid_a[idx] = 1'b0;
  endtask

  // Wait (bounded) for a start bit, pop the expected word, check each level
  // cycle by cycle. Optionally changes data at frame cycle chg_at.
  task automatic recv(input int idx, input int chg_at, input logic [7:0] chg_val,
                      output int fall_cyc);
    logic       lv [12];
    logic [7:0] w;
    logic [7:0] rx;
    int         nlev;
    bit         got;
    bit         ok;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sig_a[idx] === 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("frame_start%0d", idx), 32'(got), 32'd1);
    fall_cyc = cyc;
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    nlev = 1 + 8 + ((par_cfg[idx] != 0) ? 1 : 0) + stop_cfg[idx];
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i + 1] = w[i];
    for (int i = 9; i < 12; i++) lv[i] = 1'b1;
    if (par_cfg[idx] == 2) lv[9] = ^w;
    if (par_cfg[idx] == 1) lv[9] = ~(^w);
    rx = 8'h00;
    for (int l = 0; l < nlev; l++) begin
      ok = 1'b1;
      for (int c = 0; c < PW; c++) begin
        if (l != 0 || c != 0) @(negedge clk);
        if (sig_a[idx] !== lv[l]) ok = 1'b0;
        if (l >= 1 && l <= 8 && c == PW / 2) rx[l - 1] = sig_a[idx];
        if (l * PW + c == 50) begin
          check($sformatf("mid_busy%0d", idx), 32'(busy_a[idx]), 32'd1);
          check($sformatf("mid_ready%0d", idx), 32'(ready_a[idx]), 32'd0);
        end
        if (l * PW + c == chg_at) data_a[idx] = chg_val;
      end
      check($sformatf("u%0d_w%02h_level%0d_exact", idx, w, l), 32'(ok), 32'd1);
    end
    check($sformatf("rx_word%0d", idx), 32'(rx), 32'(w));
    check($sformatf("ready_after_frame%0d", idx), 32'(ready_a[idx]), 32'd1);
  endtask

  initial begin
    int hs;
    int f1;
    int f2;
    bit idle_ok;
    bit got;
    for (int i = 0; i < 3; i++) begin
      data_a[i]  = 8'h00;
      valid_a[i] = 1'b0;
    end

    // Reset for 5 cycles, then idle.
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_sig%0d", i), 32'(sig_a[i]), 32'd1);
      check($sformatf("rst_ready%0d", i), 32'(ready_a[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy_a[i]), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("ready_after_rst%0d", i), 32'(ready_a[i]), 32'd1);
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (sig_a[i] !== 1'b1) idle_ok = 1'b0;
    end
    check("idle_line_high", 32'(idle_ok), 32'd1);

    // Single 0x55 frame, no parity, one-cycle valid.
    send(0, 8'h55, 1'b0, 1'b1, hs);
    recv(0, -1, 8'h00, f1);
    check("start_latency", 32'(f1 - hs), 32'd1);

    // Parity bit for 0x07: even -> 1, odd -> 0.
    send(1, 8'h07, 1'b0, 1'b1, hs);
    recv(1, -1, 8'h00, f1);
    send(2, 8'h07, 1'b0, 1'b1, hs);
    recv(2, -1, 8'h00, f1);

    // Back-to-back 0xA3, 0x3C with valid held (even parity, 2 stop bits).
    send(1, 8'hA3, 1'b1, 1'b1, hs);
    data_a[1] = 8'h3C;
    exp_q.push_back(8'h3C);
    recv(1, -1, 8'h00, f1);
    @(negedge clk);
    valid_a[1] = 1'b0;
    recv(1, -1, 8'h00, f2);
    check("b2b_period", 32'(f2 - f1), 32'd121);

    // Hold/ignore: valid held with 0xFF while busy, data becomes 0x00 mid-frame.
    send(0, 8'h3C, 1'b0, 1'b1, hs);
    valid_a[0] = 1'b1;
    data_a[0]  = 8'hFF;
    exp_q.push_back(8'h00);
    recv(0, 50, 8'h00, f1);
    @(negedge clk);
    valid_a[0] = 1'b0;
    recv(0, -1, 8'h00, f2);
    check("hold_period", 32'(f2 - f1), 32'd101);

    // Reset at cycle 35 of a 0x00 frame, then a clean 0x81 frame.
    send(0, 8'h00, 1'b0, 1'b0, hs);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sig_a[0] === 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_frame_start", 32'(got), 32'd1);
    repeat (34) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_sig", 32'(sig_a[0]), 32'd1);
    check("abort_busy", 32'(busy_a[0]), 32'd0);
    check("abort_ready", 32'(ready_a[0]), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_ready_release", 32'(ready_a[0]), 32'd1);
    check("abort_sig_release", 32'(sig_a[0]), 32'd1);
    send(0, 8'h81, 1'b0, 1'b1, hs);
    recv(0, -1, 8'h00, f1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
